// File: rtl/led_rom_sequencer.sv
// led_rom_sequencer
//   Steps an 8-bit ROM address at a button-selectable rate. Each word is
//   fetched over a req/ack handshake and latched onto the LEDs. Raw
//   active-low buttons are synchronised and debounced locally.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_p      pause/resume button (raw, active-low)
//   btn_spdup  speed-up button (raw, active-low)
//   btn_spddn  speed-down button (raw, active-low)
//   rom_req    fetch request, held until rom_ack
//   rom_addr   fetch address, stable while rom_req=1
//   rom_ack    ROM data valid this cycle
//   rom_data   ROM word, sampled when rom_ack=1
//   addr       current display address
//   led_data   word driven to the LEDs
//   paused     1 while stepping is frozen
//   speed_lvl  current speed level (0 fastest, 7 slowest)
module led_rom_sequencer #(
  parameter int unsigned BASE_PERIOD     = 2_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 200_000,
  parameter int unsigned ADDR_MAX        = 255,
  parameter int unsigned DEFAULT_LVL     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_p,
  input  logic       btn_spdup,
  input  logic       btn_spddn,
  output logic       rom_req,
  output logic [7:0] rom_addr,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output logic [7:0] addr,
  output logic [7:0] led_data,
  output logic       paused,
  output logic [2:0] speed_lvl
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CNT_W = $clog2(BASE_PERIOD) + 8;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_START,
    S_REQ,
    S_RUN,
    S_PAUSE
  } state_t;

  // Button index: 0 = pause, 1 = speed up, 2 = speed down
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_level;
  logic [DB_W-1:0] r_dbc [3];
  logic [2:0]      w_press;

  state_t          r_state;
  logic            r_pend;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [CNT_W-1:0] w_term;
  logic            w_tick;
  logic [2:0]      w_lvl_next;
  logic            w_lvl_chg;
  logic            w_pend_next;
  logic [7:0]      w_addr_next;

  assign w_raw = {btn_spddn, btn_spdup, btn_p};

  // Synchroniser + debounce. The counter runs only while the synchronised
  // level differs from the accepted one, so any bounce back to the accepted
  // level restarts the stability window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_level <= '1;
      for (int unsigned i = 0; i < 3; i++) r_dbc[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DB_LAST) begin
          r_level[i] <= r_sync2[i];
          r_dbc[i]   <= '0;
        end else begin
          r_dbc[i] <= r_dbc[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle press pulse on the cycle the 1->0 level is accepted
  always_comb begin
    w_press = '0;
    for (int unsigned i = 0; i < 3; i++)
      w_press[i] = r_level[i] & ~r_sync2[i] & (r_dbc[i] == DB_LAST);
  end

  always_comb begin
    w_lvl_next = speed_lvl;
    if (w_press[1] && !w_press[2] && speed_lvl != 3'd0)
      w_lvl_next = speed_lvl - 1'b1;
    else if (w_press[2] && !w_press[1] && speed_lvl != 3'd7)
      w_lvl_next = speed_lvl + 1'b1;
  end

  assign w_lvl_chg   = (w_lvl_next != speed_lvl);
  assign w_pend_next = r_pend ^ w_press[0];
  assign w_term      = (CNT_W'(BASE_PERIOD) << speed_lvl) - 1'b1;
  assign w_tick      = (r_state == S_RUN) && (r_tick_cnt == w_term);
  assign w_addr_next = (addr == 8'(ADDR_MAX)) ? '0 : addr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_START;
      r_pend     <= 1'b0;
      r_tick_cnt <= '0;
      addr       <= '0;
      rom_addr   <= '0;
      rom_req    <= 1'b0;
      led_data   <= '0;
      paused     <= 1'b0;
      speed_lvl  <= 3'(DEFAULT_LVL);
    end else begin
      speed_lvl <= w_lvl_next;
      r_pend    <= w_pend_next;

      // Counter only advances in RUN, so it holds its value across PAUSE
      // and across a fetch.
      if (w_lvl_chg || w_tick)
        r_tick_cnt <= '0;
      else if (r_state == S_RUN)
        r_tick_cnt <= r_tick_cnt + 1'b1;

      case (r_state)
        S_START: begin
          rom_req  <= 1'b1;
          rom_addr <= addr;
          r_state  <= S_REQ;
        end
        S_REQ: begin
          // Pause presses during a fetch are only recorded in r_pend and
          // take effect once the word has been latched.
          if (rom_ack) begin
            led_data <= rom_data;
            rom_req  <= 1'b0;
            paused   <= w_pend_next;
            r_state  <= w_pend_next ? S_PAUSE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_tick) begin
            addr     <= w_addr_next;
            rom_addr <= w_addr_next;
            rom_req  <= 1'b1;
            r_state  <= S_REQ;
          end else if (w_press[0]) begin
            paused  <= 1'b1;
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_press[0]) begin
            paused  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_led_rom_sequencer.sv
module tb_led_rom_sequencer;

  localparam int BP = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btn = 3'b111;   // {spddn, spdup, p}
  logic       rom_req;
  logic [7:0] rom_addr;
  logic       rom_ack = 1'b0;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] addr;
  logic [7:0] led_data;
  logic       paused;
  logic [2:0] speed_lvl;

  int n_cmp = 0;
  int n_bad = 0;
  bit spur_en = 1'b0;
  int rc = 0;

  led_rom_sequencer #(
    .BASE_PERIOD(BP),
    .DEBOUNCE_CYCLES(DB),
    .ADDR_MAX(255),
    .DEFAULT_LVL(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_p(btn[0]),
    .btn_spdup(btn[1]),
    .btn_spddn(btn[2]),
    .rom_req(rom_req),
    .rom_addr(rom_addr),
    .rom_ack(rom_ack),
    .rom_data(rom_data),
    .addr(addr),
    .led_data(led_data),
    .paused(paused),
    .speed_lvl(speed_lvl)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within bound at %0t", nm, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit [2:0] mask);
    btn = ~mask;
    cyc(12);
    btn = 3'b111;
    cyc(12);
  endtask

  // ROM: data = addr ^ A5, ack two cycles after req; optional stray acks
  // while no request is outstanding.
  always @(negedge clk) begin
    if (rst) begin
      rom_ack = 1'b0;
      rc = 0;
    end else if (rom_ack) begin
      rom_ack = 1'b0;
    end else if (rom_req) begin
      rc++;
      if (rc == 2) begin
        rom_ack  = 1'b1;
        rom_data = rom_addr ^ 8'hA5;
        rc = 0;
      end
    end else begin
      rc = 0;
      if (spur_en && $urandom_range(0, 9) == 0) begin
        rom_ack  = 1'b1;
        rom_data = 8'($urandom);
      end
    end
  end

  // Behavioural reference model
  bit m_started, m_fetch, m_req, m_paused, m_pend;
  int m_addr, m_led, m_rom_addr, m_lvl, m_cnt;
  bit d1[3], d2[3], acc[3];
  int run[3];
  bit [2:0] pr;
  int nl, per;
  bit pn, tk, was_running;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_fetch = 0; m_req = 0; m_paused = 0; m_pend = 0;
      m_addr = 0; m_led = 0; m_rom_addr = 0; m_lvl = 3; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
        d1[i] = 1; d2[i] = 1; acc[i] = 1; run[i] = 0;
      end
    end else begin
      // Button seen two clocks late; accepted after DB consecutive
      // differing samples; press on accepted low.
      for (int i = 0; i < 3; i++) begin
        pr[i] = 1'b0;
        if (d2[i] != acc[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            acc[i] = d2[i];
            run[i] = 0;
            pr[i] = (d2[i] == 1'b0);
          end
        end else begin
          run[i] = 0;
        end
        d2[i] = d1[i];
        d1[i] = btn[i];
      end

      nl = m_lvl;
      if (pr[1] && !pr[2]) nl = (m_lvl > 0) ? m_lvl - 1 : 0;
      if (pr[2] && !pr[1]) nl = (m_lvl < 7) ? m_lvl + 1 : 7;
      per = BP * (1 << m_lvl);
      pn = m_pend ^ pr[0];
      tk = 1'b0;
      was_running = m_started && !m_fetch && !m_paused;

      if (!m_started) begin
        m_started = 1; m_fetch = 1; m_req = 1; m_rom_addr = m_addr;
      end else if (m_fetch) begin
        if (rom_ack) begin
          m_led = rom_data; m_req = 0; m_fetch = 0; m_paused = pn;
        end
      end else if (!m_paused && m_cnt == per - 1) begin
        tk = 1'b1;
        m_addr = (m_addr + 1) % 256;
        m_rom_addr = m_addr;
        m_req = 1; m_fetch = 1;
      end else begin
        m_paused = pn;
      end

      if (nl != m_lvl || tk) m_cnt = 0;
      else if (was_running) m_cnt++;
      m_lvl = nl;
      m_pend = pn;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      cmp("rom_req",   rom_req,   m_req);
      cmp("rom_addr",  rom_addr,  m_rom_addr);
      cmp("addr",      addr,      m_addr);
      cmp("led_data",  led_data,  m_led);
      cmp("paused",    paused,    m_paused);
      cmp("speed_lvl", speed_lvl, m_lvl);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    cyc(3);
    cmp("rst_req",   rom_req, 0);
    cmp("rst_addr",  addr, 0);
    cmp("rst_led",   led_data, 0);
    cmp("rst_speed", speed_lvl, 3);
    cmp("rst_pause", paused, 0);
    rst = 1'b0;

    cyc(1);
    cmp("first_req",  rom_req, 1);
    cmp("first_addr", rom_addr, 0);
    cyc(3);
    cmp("first_led", led_data, 8'hA5);
    cyc(36);
    cmp("step1_addr", addr, 1);
    cmp("step1_led",  led_data, 8'hA4);
    cyc(30);
    cmp("step2_addr", addr, 2);

    // Pause: glitch ignored, real press pauses, second press resumes
    btn[0] = 1'b0; cyc(5); btn[0] = 1'b1; cyc(12);
    cmp("glitch_nopause", paused, 0);
    btn[0] = 1'b0; cyc(20); btn[0] = 1'b1; cyc(12);
    cmp("pause_on", paused, 1);
    cyc(100);
    cmp("pause_hold", paused, 1);
    press(3'b001);
    cmp("pause_off", paused, 0);

    // Speed
    repeat (3) press(3'b010);
    cmp("spd_up3", speed_lvl, 0);
    press(3'b010);
    cmp("spd_up_sat", speed_lvl, 0);
    repeat (8) press(3'b100);
    cmp("spd_dn_sat", speed_lvl, 7);
    press(3'b110);
    cmp("spd_both", speed_lvl, 7);
    cyc(600);
    repeat (7) press(3'b010);
    cmp("spd_back0", speed_lvl, 0);

    // Address wrap
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (m_addr == 255) ok = 1; else cyc(1);
    end
    if (!ok) timeout_fail("reach_255");
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (m_addr == 0 && !m_fetch) ok = 1; else cyc(1);
    end
    if (!ok) timeout_fail("wrap_fetch");
    cmp("wrap_addr", addr, 0);
    cmp("wrap_romaddr", rom_addr, 0);
    cmp("wrap_led", led_data, 8'hA5);

    // Pause press accepted while a fetch is outstanding
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (!m_req) ok = 1; else cyc(1);
    end
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (m_req) ok = 1; else cyc(1);
    end
    if (!ok) timeout_fail("req_rise");
    cyc(3);
    btn[0] = 1'b0; cyc(12); btn[0] = 1'b1; cyc(12);
    cmp("req_pause", paused, 1);
    press(3'b001);
    cmp("req_resume", paused, 0);

    // Reset in the middle of a fetch
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (m_req) ok = 1; else cyc(1);
    end
    if (!ok) timeout_fail("req_for_rst");
    #2 rst = 1'b1;
    #1 cmp("rst_async_req", rom_req, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    cmp("refetch_req",  rom_req, 1);
    cmp("refetch_addr", rom_addr, 0);
    cmp("refetch_spd",  speed_lvl, 3);

    // Random button activity with stray acks
    spur_en = 1'b1;
    for (int s = 0; s < 120; s++) begin
      for (int b = 0; b < 3; b++) btn[b] = ($urandom_range(0, 2) != 0);
      cyc($urandom_range(1, 30));
    end
    btn = 3'b111;
    spur_en = 1'b0;
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
